input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Upstream stage that produces the x1/x2/x3 inputs for the registered AND/OR pipeline stage.
- Takes three raw, asynchronous, possibly bouncing signals (pins or switches) and passes each through a 2-flop synchroniser and a per-channel debounce filter.
- Drives clean, glitch-free x1, x2, x3 plus one-cycle change strobes, all in the clk domain.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clocks a synchronised input must differ from the filtered output before the output follows it. Legal range 2..2^CNT_W-1.
- CNT_W, 16: width of each channel's debounce counter.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  filter enable; 0 freezes the filter state
- raw_x1  input  1  asynchronous raw channel 0
- raw_x2  input  1  asynchronous raw channel 1
- raw_x3  input  1  asynchronous raw channel 2
- x1  output  1  filtered channel 0 (registered)
- x2  output  1  filtered channel 1 (registered)
- x3  output  1  filtered channel 2 (registered)
- x_chg  output  3  per-channel one-cycle toggle strobe; bit0=x1, bit1=x2, bit2=x3

Behaviour:
- Reset (async, active-high): sync flops, counters, x1..x3 and x_chg all go to 0 immediately, regardless of clk.
- Reset mid-debounce discards the partial count. After release, a level already high at the inputs is re-qualified from scratch.
- Synchroniser:
  - s1 <= raw each clk; s2 <= s1.
  - Runs regardless of en.
  - s2 is the only value the filter sees.
- Filter, per channel, each clk with en=1:
  - s2 == x: cnt <= 0.
  - s2 != x and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != x and cnt == DEBOUNCE_CYCLES-1: x <= s2, cnt <= 0, x_chg[i] <= 1.
  - x_chg[i] <= 0 in every other cycle, so it is high exactly in the cycle the new x value is visible.
- Any cycle with s2 == x during a pending count aborts it (cnt back to 0). Bounce shorter than DEBOUNCE_CYCLES therefore never reaches x.
- en=0: cnt and x hold; x_chg forced 0. On en re-assert, counting resumes from the held cnt.
- Latency for a clean step on raw that meets setup before edge E0: x changes after edge E0+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges counting E0; 6 edges at default.
- Channels are fully independent. Simultaneous qualification on several channels sets several x_chg bits in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Rising and falling transitions are qualified symmetrically.

Optional Feature:
- Macro: INPUT_COND_GLITCH_CNT_EN.
- Defined:
  - Adds input glitch_clr (1 bit) and output glitch_cnt (8 bits, registered, reset 0).
  - glitch_cnt increments by the number of channels (0..3) whose pending count aborts in that cycle, i.e. cnt != 0 and s2 == x with en=1.
  - Saturates at 255, no wrap.
  - glitch_clr=1 sets it to 0 and takes priority over an increment in the same cycle.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Shared package/include input_cond_pkg:
  - localparams N_CH=3, default DEBOUNCE_CYCLES=4, CNT_W=16, GLITCH_W=8.
  - Channel index constants CH_X1=0, CH_X2=1, CH_X3=2.
- One sub-module, debounce_ch: synchroniser, counter and filtered bit for a single channel.
  - Ports: clk, rst, en, raw, x, chg, abort.
  - Instantiated 3 times.
  - The top level maps the instances to x1/x2/x3 and x_chg, and holds the optional glitch counter.

Test Plan:
- Reset and clean rise: hold rst 3 cycles, raw_x1=1 steady before release → x1=0, x_chg=0 during reset. After release, x1 rises on the 6th edge with x_chg=3'b001 for exactly that one cycle.
- Bounce rejection: raw_x2 toggles 1,0,1,0 every clk for 12 cycles, then stays 0 → x2 stays 0 throughout, x_chg[1] never set. With the macro, glitch_cnt counts the aborts (expected 6).
- Simultaneous channels: raw_x1 and raw_x3 rise at the same edge → x1 and x3 rise on the same cycle, x_chg=3'b101; x2 and x_chg[1] stay 0.
- Enable freeze: raw_x1 rises, en=0 after 3 filter counts for 5 cycles, then en=1 → x1 rises exactly 1 cycle after en returns. x_chg stays 0 while en=0.
- Async reset mid-count: x3=1 stable, raw_x3 falls, rst pulsed (not clk-aligned) during the count → x3 goes 0 immediately at rst. After release with raw_x3=0, x3 stays 0 and x_chg stays 0.
- Saturation and clear (macro on): force more than 255 aborts → glitch_cnt holds 255. Assert glitch_clr in a cycle with an abort → glitch_cnt=0 the next cycle.

Source files
------------

// File: rtl/input_cond_pkg.sv
// -----------------------------------------------------------------------------
// input_cond_pkg
//   Shared constants and helpers for the input_conditioner slice.
//   - N_CH          : number of conditioned channels (x1, x2, x3)
//   - CH_X1..CH_X3  : channel index of each output inside the channel vectors
//   - DEBOUNCE_CYCLES_DEFAULT / CNT_W_DEFAULT : default filter configuration
//   - GLITCH_W      : width of the optional aborted-bounce counter
//   Helpers: count_set (popcount of a channel vector) and sat_add (saturating
//   add used by the optional glitch counter).
// -----------------------------------------------------------------------------
package input_cond_pkg;

  localparam int N_CH                    = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int CNT_W_DEFAULT           = 16;
  localparam int GLITCH_W                = 8;

  localparam int CH_X1 = 0;
  localparam int CH_X2 = 1;
  localparam int CH_X3 = 2;

  // Number of set bits in a per-channel vector (0..N_CH fits in 2 bits).
  function automatic logic [1:0] count_set(input logic [N_CH-1:0] v);
    logic [1:0] n;
    n = '0;
    for (int i = 0; i < N_CH; i++) begin
      n = n + {1'b0, v[i]};
    end
    return n;
  endfunction

  // a + b, clamped at the all-ones value instead of wrapping.
  function automatic logic [GLITCH_W-1:0] sat_add(input logic [GLITCH_W-1:0] a,
                                                  input logic [1:0]          b);
    logic [GLITCH_W:0] s;
    s = {1'b0, a} + {{(GLITCH_W-1){1'b0}}, b};
    return s[GLITCH_W] ? {GLITCH_W{1'b1}} : s[GLITCH_W-1:0];
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
//   One conditioned channel: 2-flop synchroniser followed by a debounce filter.
//   The filtered bit x only follows the synchronised input after it has
//   disagreed with x for DEBOUNCE_CYCLES consecutive enabled clocks.
//
// Ports
//   clk   in   system clock, all state on rising edge
//   rst   in   asynchronous active-high reset
//   en    in   filter enable; 0 holds counter and x (synchroniser keeps running)
//   raw   in   asynchronous raw input
//   x     out  filtered level (registered)
//   chg   out  one-cycle strobe, high in the cycle the new x is visible
//   abort out  combinational: a pending count is being discarded this cycle
//
// Parameters
//   DEBOUNCE_CYCLES  qualification length, legal range 2 .. 2**CNT_W-1
//   CNT_W            counter width
// -----------------------------------------------------------------------------
module debounce_ch
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic x,
  output logic chg,
  output logic abort
);

  // Counter value at which the next disagreeing sample qualifies; the counter
  // never goes past it, so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Synchroniser: free-running, independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce filter. Only s2 is looked at; s1 may still be metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      x   <= 1'b0;
      chg <= 1'b0;
    end else if (!en) begin
      chg <= 1'b0;
    end else if (s2 == x) begin
      cnt <= '0;
      chg <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      x   <= s2;
      cnt <= '0;
      chg <= 1'b1;
    end else begin
      cnt <= cnt + CNT_W'(1);
      chg <= 1'b0;
    end
  end

  // A non-zero count with the input back at x means a bounce is being thrown
  // away in this clock.
  assign abort = en & (cnt != '0) & (s2 == x);

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Produces clean x1/x2/x3 for the downstream registered AND/OR stage from
//   three raw asynchronous, possibly bouncing, inputs. Each channel is a
//   debounce_ch instance (synchroniser + filter); channels are independent.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   en         in   filter enable (0 freezes filter state, forces x_chg=0)
//   raw_x1..3  in   asynchronous raw channels 0..2
//   x1..x3     out  filtered channels (registered)
//   x_chg[2:0] out  one-cycle change strobes, bit0=x1, bit1=x2, bit2=x3
//
// Optional feature, macro INPUT_COND_GLITCH_CNT_EN:
//   glitch_clr     in   synchronous clear of glitch_cnt (wins over increment)
//   glitch_cnt[7:0] out saturating count of aborted pending debounces
// -----------------------------------------------------------------------------
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            raw_x1,
  input  logic            raw_x2,
  input  logic            raw_x3,
  output logic            x1,
  output logic            x2,
  output logic            x3,
  output logic [N_CH-1:0] x_chg
`ifdef INPUT_COND_GLITCH_CNT_EN
  ,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  logic [N_CH-1:0] raw_vec;
  logic [N_CH-1:0] x_vec;
  logic [N_CH-1:0] chg_vec;
  logic [N_CH-1:0] abort_vec;

  assign raw_vec[CH_X1] = raw_x1;
  assign raw_vec[CH_X2] = raw_x2;
  assign raw_vec[CH_X3] = raw_x3;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .raw   (raw_vec[i]),
      .x     (x_vec[i]),
      .chg   (chg_vec[i]),
      .abort (abort_vec[i])
    );
  end

  assign x1    = x_vec[CH_X1];
  assign x2    = x_vec[CH_X2];
  assign x3    = x_vec[CH_X3];
  assign x_chg = chg_vec;

`ifdef INPUT_COND_GLITCH_CNT_EN
  // Several channels can abort in the same clock, so add the popcount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else begin
      glitch_cnt <= sat_add(glitch_cnt, count_set(abort_vec));
    end
  end
`else
  // Abort flags have no consumer without the glitch counter.
  logic unused_abort;
  assign unused_abort = ^abort_vec;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//   Directed scenarios followed by a randomized phase. A reference model states
//   the filter rule directly: keep the synchronised samples seen while enabled;
//   once the last DEBOUNCE_CYCLES of them all differ from x, x takes the new
//   value and the history restarts. Glitch checks exist only when
//   INPUT_COND_GLITCH_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       raw_x1, raw_x2, raw_x3;
  logic       x1, x2, x3;
  logic [2:0] x_chg;
`ifdef INPUT_COND_GLITCH_CNT_EN
  logic       glitch_clr;
  logic [7:0] glitch_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit [2:0] ms1, ms2, mx, mchg;
  int       mg;
  bit       q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .raw_x1 (raw_x1),
    .raw_x2 (raw_x2),
    .raw_x3 (raw_x3),
    .x1     (x1),
    .x2     (x2),
    .x3     (x3),
    .x_chg  (x_chg)
`ifdef INPUT_COND_GLITCH_CNT_EN
    ,
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms1 = '0; ms2 = '0; mx = '0; mchg = '0; mg = 0;
    q0.delete(); q1.delete(); q2.delete();
  endtask

  // One channel: history of enabled samples, qualification when the last D
  // samples all disagree with x. 'ab' = pending disagreement run broken now.
  task automatic ch_step(ref bit q[$], input bit mx_in, input bit s2,
                         output bit mx_out, output bit chg, output bit ab);
    int  trailing;
    bool_all: begin end
    trailing = 0;
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (q[j] == mx_in) break;
      trailing++;
    end
    ab     = (trailing > 0) && (s2 == mx_in);
    mx_out = mx_in;
    chg    = 1'b0;
    q.push_back(s2);
    if (q.size() > D) void'(q.pop_front());
    if (q.size() == D) begin
      int ndiff;
      ndiff = 0;
      for (int j = 0; j < D; j++) if (q[j] != mx_in) ndiff++;
      if (ndiff == D) begin
        mx_out = s2;
        chg    = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic model_edge();
    bit [2:0] s2v;
    bit       nx, c, a;
    int       ab;
    if (rst) begin
      model_reset();
      return;
    end
    s2v  = ms2;
    ms2  = ms1;
    ms1  = {raw_x3, raw_x2, raw_x1};
    mchg = '0;
    ab   = 0;
    if (en) begin
      ch_step(q0, mx[0], s2v[0], nx, c, a); mx[0] = nx; mchg[0] = c; ab += int'(a);
      ch_step(q1, mx[1], s2v[1], nx, c, a); mx[1] = nx; mchg[1] = c; ab += int'(a);
      ch_step(q2, mx[2], s2v[2], nx, c, a); mx[2] = nx; mchg[2] = c; ab += int'(a);
    end
`ifdef INPUT_COND_GLITCH_CNT_EN
    if (glitch_clr) mg = 0;
    else mg = (mg + ab > 255) ? 255 : mg + ab;
`endif
  endtask

  // Advance one clock, update the model, then compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_x", {29'd0, x3, x2, x1}, {29'd0, mx});
    check("model_chg", {29'd0, x_chg}, {29'd0, mchg});
`ifdef INPUT_COND_GLITCH_CNT_EN
    check("model_glitch", {24'd0, glitch_cnt}, mg);
`endif
  endtask

  task automatic drive(input logic r1, input logic r2, input logic r3);
    raw_x1 = r1; raw_x2 = r2; raw_x3 = r3;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
`ifdef INPUT_COND_GLITCH_CNT_EN
    glitch_clr = 1'b0;
`endif
    model_reset();

    // Reset held with raw_x1 high, then clean rise on the 6th edge.
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_x1", {31'd0, x1}, 32'd0);
      check("rst_chg", {29'd0, x_chg}, 32'd0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("rise_x1", {31'd0, x1}, (k >= 6) ? 32'd1 : 32'd0);
      check("rise_chg", {29'd0, x_chg}, (k == 6) ? 32'd1 : 32'd0);
    end

    // Simultaneous rise on x1 and x3.
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step();
    drive(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      step();
      check("sim_x", {29'd0, x3, x2, x1}, (k >= 6) ? 32'd5 : 32'd0);
      check("sim_chg", {29'd0, x_chg}, (k == 6) ? 32'd5 : 32'd0);
    end

    // Enable freeze after three filter counts.
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step();
    drive(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("frz_x1", {31'd0, x1}, 32'd0);
      check("frz_chg", {29'd0, x_chg}, 32'd0);
    end
    en = 1'b1;
    step();
    check("frz_rise_x1", {31'd0, x1}, 32'd1);
    check("frz_rise_chg", {29'd0, x_chg}, 32'd1);
    step();
    check("frz_chg_clr", {29'd0, x_chg}, 32'd0);

    // Asynchronous reset in the middle of a falling count on x3.
    check("pre_rst_x3", {31'd0, x3}, 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step();
    #3 rst = 1'b1;
    #1;
    check("arst_x", {29'd0, x3, x2, x1}, 32'd0);
    check("arst_chg", {29'd0, x_chg}, 32'd0);
    model_reset();
    #3 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("post_rst_x3", {31'd0, x3}, 32'd0);
      check("post_rst_chg", {29'd0, x_chg}, 32'd0);
    end

    // Bounce rejection on x2.
`ifdef INPUT_COND_GLITCH_CNT_EN
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
`endif
    for (int k = 0; k < 12; k++) begin
      raw_x2 = ~k[0];
      step();
      check("bnc_x2", {31'd0, x2}, 32'd0);
      check("bnc_chg1", {31'd0, x_chg[1]}, 32'd0);
    end
    raw_x2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bnc_tail_x2", {31'd0, x2}, 32'd0);
    end
`ifdef INPUT_COND_GLITCH_CNT_EN
    check("bnc_glitch", {24'd0, glitch_cnt}, 32'd6);

    // Saturation, then clear with aborts in flight.
    for (int k = 0; k < 240; k++) begin
      drive(k[0], k[0], k[0]);
      step();
    end
    check("sat_glitch", {24'd0, glitch_cnt}, 32'd255);
    glitch_clr = 1'b1;
    for (int k = 240; k < 242; k++) begin
      drive(k[0], k[0], k[0]);
      step();
      check("clr_glitch", {24'd0, glitch_cnt}, 32'd0);
    end
    glitch_clr = 1'b0;
`endif

    // Randomized phase.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) raw_x1 = ~raw_x1;
      if ($urandom_range(0, 5) == 0) raw_x2 = ~raw_x2;
      if ($urandom_range(0, 5) == 0) raw_x3 = ~raw_x3;
      en = ($urandom_range(0, 9) != 0);
`ifdef INPUT_COND_GLITCH_CNT_EN
      glitch_clr = ($urandom_range(0, 49) == 0);
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
